// File: rtl/am_lock_pkg.sv
// Shared constants, types and marker matching for the 40GBASE-R alignment-marker lock stage.
package am_lock_pkg;

    localparam int         LANE_ID_W = 2;
    localparam logic [1:0] SYNC_AM   = 2'b10;

    typedef logic [LANE_ID_W-1:0] lane_id_t;
    typedef enum logic [1:0] {ST_SEARCH, ST_CONFIRM, ST_LOCKED} lock_state_e;

    // One block's marker fields with the BIP bytes stripped: {M6,M5,M4,M2,M1,M0,sync}.
    typedef logic [49:0] am_fields_t;

    function automatic logic [23:0] am_marker(input lane_id_t id);
        case (id)
            2'd0:    return 24'h90_76_47;
            2'd1:    return 24'hF0_C4_E6;
            2'd2:    return 24'hC5_65_9B;
            default: return 24'hA2_79_3D;
        endcase
    endfunction

    function automatic logic am_match(input am_fields_t f, input lane_id_t id);
        logic [23:0] m012;
        logic [23:0] m456;
        m012 = {f[9:2], f[17:10], f[25:18]};
        m456 = {f[33:26], f[41:34], f[49:42]};
        return (f[1:0] == SYNC_AM) && (m012 == am_marker(id)) && (m456 == ~am_marker(id));
    endfunction

endpackage

// File: rtl/am_lock_lane_rx.sv
// One lane's AM matcher, SEARCH/CONFIRM/LOCKED FSM, period counter and bad-AM counter.
module am_lock_lane_rx
    import am_lock_pkg::*;
#(
    parameter int AM_GAP_N = 16384,
    parameter int AM_CNT_W = $clog2(AM_GAP_N),
    parameter int AM_BAD_N = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       blk_lock_i,
    input  logic       data_v_i,
    input  am_fields_t am_fields_i,
    output logic       am_lock_o,
    output logic       am_lite_v_o,
    output lane_id_t   lane_id_o,
    output logic       am_lite_v_nxt_o,
    output logic       lock_drop_nxt_o
);

    localparam int                  BAD_W    = $clog2(AM_BAD_N + 1);
    localparam logic [AM_CNT_W-1:0] CNT_LAST = AM_CNT_W'(AM_GAP_N - 1);
    localparam logic [BAD_W-1:0]    BAD_LAST = BAD_W'(AM_BAD_N - 1);

    lock_state_e         state_d, state_q;
    logic [AM_CNT_W-1:0] cnt_d, cnt_q;
    logic [BAD_W-1:0]    bad_d, bad_q;
    lane_id_t            id_d, id_q;
    logic                am_lock_d, am_lock_q;
    logic                am_lite_v_d, am_lite_v_q;
    logic                any_hit, own_hit, at_check;
    lane_id_t            hit_id;

    always_comb begin
        any_hit = 1'b0;
        hit_id  = '0;
        for (int i = 0; i < 2**LANE_ID_W; i++) begin
            if (am_match(am_fields_i, lane_id_t'(i))) begin
                any_hit = 1'b1;
                hit_id  = lane_id_t'(i);
            end
        end
    end

    assign own_hit = am_match(am_fields_i, id_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bad_d       = bad_q;
        id_d        = id_q;
        am_lock_d   = am_lock_q;
        am_lite_v_d = 1'b0;
        at_check    = data_v_i && (cnt_q == CNT_LAST);

        if (data_v_i) cnt_d = at_check ? '0 : cnt_q + AM_CNT_W'(1);

        // Loss of block lock beats any marker seen on the same block.
        if (!blk_lock_i) begin
            state_d   = ST_SEARCH;
            bad_d     = '0;
            am_lock_d = 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: if (data_v_i && any_hit) begin
                    id_d    = hit_id;
                    cnt_d   = '0;
                    state_d = ST_CONFIRM;
                end
                ST_CONFIRM: if (at_check) begin
                    if (own_hit) begin
                        state_d     = ST_LOCKED;
                        am_lock_d   = 1'b1;
                        am_lite_v_d = 1'b1;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: if (at_check) begin
                    if (own_hit) begin
                        bad_d       = '0;
                        am_lite_v_d = 1'b1;
                    end else if (bad_q == BAD_LAST) begin
                        state_d   = ST_SEARCH;
                        bad_d     = '0;
                        am_lock_d = 1'b0;
                    end else begin
                        bad_d = bad_q + BAD_W'(1);
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= ST_SEARCH;
            cnt_q       <= '0;
            bad_q       <= '0;
            id_q        <= '0;
            am_lock_q   <= 1'b0;
            am_lite_v_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            id_q        <= id_d;
            am_lock_q   <= am_lock_d;
            am_lite_v_q <= am_lite_v_d;
        end
    end

    assign am_lock_o       = am_lock_q;
    assign am_lite_v_o     = am_lite_v_q;
    assign lane_id_o       = id_q;
    assign am_lite_v_nxt_o = am_lite_v_d;
    assign lock_drop_nxt_o = !blk_lock_i || (state_q == ST_LOCKED && state_d != ST_LOCKED);

endmodule

// File: rtl/am_lock_rx.sv
// Multi-lane AM lock stage: per-lane lock FSMs, one-cycle data pipeline, all-lanes-locked and id-uniqueness flags.
module am_lock_rx
    import am_lock_pkg::*;
#(
    parameter int LANE_N   = 4,
    parameter int BLOCK_W  = 66,
    parameter int AM_GAP_N = 16384,
    parameter int AM_CNT_W = $clog2(AM_GAP_N),
    parameter int AM_BAD_N = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LANE_N-1:0]           blk_lock_i,
    input  logic                        data_v_i,
    input  logic [LANE_N*BLOCK_W-1:0]   data_i,
    output logic [LANE_N*BLOCK_W-1:0]   data_o,
    output logic                        data_v_o,
    output logic [LANE_N-1:0]           am_lite_v_o,
    output logic [LANE_N-1:0]           am_lock_o,
    output logic [LANE_N*LANE_ID_W-1:0] lane_id_o,
    output logic                        am_lite_lock_full_v_o,
    output logic                        lane_id_err_o
);

    am_fields_t                am_fields [LANE_N];
    lane_id_t                  lane_id   [LANE_N];
    logic [LANE_N-1:0]         am_lock, lite_nxt, drop_nxt;
    logic [LANE_N*BLOCK_W-1:0] data_d, data_q;
    logic                      data_v_d, data_v_q;
    logic [LANE_N-1:0]         seen_d, seen_q;
    logic                      full_d, full_q;
    logic                      id_err_d, id_err_q;
    logic                      id_dup;

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        assign am_fields[l] = {data_i[l*BLOCK_W+34 +: 24], data_i[l*BLOCK_W +: 26]};

        am_lock_lane_rx #(
            .AM_GAP_N (AM_GAP_N),
            .AM_CNT_W (AM_CNT_W),
            .AM_BAD_N (AM_BAD_N)
        ) u_lane (
            .clk             (clk),
            .reset           (reset),
            .blk_lock_i      (blk_lock_i[l]),
            .data_v_i        (data_v_i),
            .am_fields_i     (am_fields[l]),
            .am_lock_o       (am_lock[l]),
            .am_lite_v_o     (am_lite_v_o[l]),
            .lane_id_o       (lane_id[l]),
            .am_lite_v_nxt_o (lite_nxt[l]),
            .lock_drop_nxt_o (drop_nxt[l])
        );

        assign lane_id_o[l*LANE_ID_W +: LANE_ID_W] = lane_id[l];
    end

    always_comb begin
        data_d   = data_i;
        data_v_d = data_v_i;
        // Any lane dropping restarts every lane's seen flag so deskew restarts together.
        seen_d   = (|drop_nxt) ? '0 : (seen_q | lite_nxt);
        full_d   = &seen_q && &am_lock;
        id_dup   = 1'b0;
        for (int i = 0; i < LANE_N; i++) begin
            for (int j = i + 1; j < LANE_N; j++) begin
                if (lane_id[i] == lane_id[j]) id_dup = 1'b1;
            end
        end
        id_err_d = &am_lock && id_dup;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            data_v_q <= 1'b0;
            seen_q   <= '0;
            full_q   <= 1'b0;
            id_err_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            data_v_q <= data_v_d;
            seen_q   <= seen_d;
            full_q   <= full_d;
            id_err_q <= id_err_d;
        end
    end

    assign am_lock_o             = am_lock;
    assign data_o                = data_q;
    assign data_v_o              = data_v_q;
    assign am_lite_lock_full_v_o = full_q;
    assign lane_id_err_o         = id_err_q;

endmodule

// File: tb/tb_am_lock_rx.sv
// Randomized scoreboard bench for am_lock_rx against a valid-block-index reference model.
module tb_am_lock_rx;

    localparam int LANE_N  = 4;
    localparam int BLOCK_W = 66;
    localparam int GAP     = 16;
    localparam int BAD_N   = 4;
    localparam int DW      = LANE_N * BLOCK_W;

    typedef logic [DW-1:0] wide_t;
    typedef struct {
        wide_t             data;
        logic              data_v;
        logic [LANE_N-1:0] lite;
        logic [LANE_N-1:0] lock;
        logic [2*LANE_N-1:0] ids;
        logic              full;
        logic              err;
    } exp_t;

    logic                clk        = 1'b0;
    logic                reset      = 1'b1;
    logic [LANE_N-1:0]   blk_lock_i = '0;
    logic                data_v_i   = 1'b0;
    wide_t               data_i     = '0;
    wide_t               data_o;
    logic                data_v_o;
    logic [LANE_N-1:0]   am_lite_v_o;
    logic [LANE_N-1:0]   am_lock_o;
    logic [2*LANE_N-1:0] lane_id_o;
    logic                full_o;
    logic                id_err_o;

    am_lock_rx #(
        .LANE_N   (LANE_N),
        .BLOCK_W  (BLOCK_W),
        .AM_GAP_N (GAP),
        .AM_CNT_W ($clog2(GAP)),
        .AM_BAD_N (BAD_N)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .blk_lock_i            (blk_lock_i),
        .data_v_i              (data_v_i),
        .data_i                (data_i),
        .data_o                (data_o),
        .data_v_o              (data_v_o),
        .am_lite_v_o           (am_lite_v_o),
        .am_lock_o             (am_lock_o),
        .lane_id_o             (lane_id_o),
        .am_lite_lock_full_v_o (full_o),
        .lane_id_err_o         (id_err_o)
    );

    always #5 clk = ~clk;

    // Stimulus generator state
    int gen_id    [LANE_N];
    int off       [LANE_N];
    int corrupt_n [LANE_N];
    bit am_en     [LANE_N];
    bit force_am  [LANE_N];
    bit corrupt_rand;
    int g_idx;

    // Reference model state: lane mode 0=search 1=confirm 2=locked
    int     m_mode   [LANE_N];
    longint m_anchor [LANE_N];
    int     m_bad    [LANE_N];
    int     m_id     [LANE_N];
    bit     m_seen   [LANE_N];
    longint m_vidx;

    exp_t exp_q[$];
    exp_t pend;
    bit   have_pend = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input wide_t act, input wide_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] marker(input int id);
        case (id)
            0:       return 24'h907647;
            1:       return 24'hF0C4E6;
            2:       return 24'hC5659B;
            default: return 24'hA2793D;
        endcase
    endfunction

    function automatic logic [BLOCK_W-1:0] rand_blk();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[BLOCK_W-1:0];
    endfunction

    function automatic logic [BLOCK_W-1:0] make_am(input int id, input bit corrupt);
        logic [BLOCK_W-1:0] b;
        logic [23:0]        m;
        m        = marker(id);
        b        = rand_blk();
        b[1:0]   = 2'b10;
        b[9:2]   = m[23:16];
        b[17:10] = m[15:8];
        b[25:18] = m[7:0];
        b[41:34] = ~m[23:16];
        b[49:42] = ~m[15:8];
        b[57:50] = ~m[7:0];
        if (corrupt) b[12] = ~b[12];
        return b;
    endfunction

    function automatic bit decode_am(input logic [BLOCK_W-1:0] b, output int id);
        id = -1;
        if (b[1:0] != 2'b10) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [23:0] m;
            m = marker(i);
            if (b[9:2] == m[23:16] && b[17:10] == m[15:8] && b[25:18] == m[7:0] &&
                b[41:34] == ~m[23:16] && b[49:42] == ~m[15:8] && b[57:50] == ~m[7:0]) begin
                id = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Expected outputs visible one cycle after these inputs are applied.
    task automatic model_step(input bit rst, input logic [LANE_N-1:0] bl, input bit dv,
                              input wide_t d, output exp_t e);
        bit all_lock, all_seen, dup, drop;
        all_lock = 1'b1;
        all_seen = 1'b1;
        dup      = 1'b0;
        drop     = 1'b0;
        for (int l = 0; l < LANE_N; l++) begin
            all_lock = all_lock && (m_mode[l] == 2);
            all_seen = all_seen && m_seen[l];
        end
        for (int i = 0; i < LANE_N; i++)
            for (int j = i + 1; j < LANE_N; j++)
                if (m_id[i] == m_id[j]) dup = 1'b1;

        e.data = '0; e.data_v = 1'b0; e.lite = '0; e.lock = '0; e.ids = '0; e.full = 1'b0; e.err = 1'b0;
        if (rst) begin
            for (int l = 0; l < LANE_N; l++) begin
                m_mode[l] = 0; m_anchor[l] = 0; m_bad[l] = 0; m_id[l] = 0; m_seen[l] = 1'b0;
            end
            m_vidx = 0;
            return;
        end

        if (dv) m_vidx++;
        for (int l = 0; l < LANE_N; l++) begin
            int hid;
            bit hit, at_period, own;
            hit       = decode_am(d[l*BLOCK_W +: BLOCK_W], hid);
            own       = hit && (hid == m_id[l]);
            at_period = dv && ((m_vidx - m_anchor[l]) % GAP == 0);
            if (!bl[l]) begin
                m_mode[l] = 0; m_bad[l] = 0; drop = 1'b1;
            end else if (dv) begin
                case (m_mode[l])
                    0: if (hit) begin
                        m_mode[l] = 1; m_id[l] = hid; m_anchor[l] = m_vidx;
                    end
                    1: if (at_period) begin
                        if (own) begin m_mode[l] = 2; e.lite[l] = 1'b1; end
                        else m_mode[l] = 0;
                    end
                    default: if (at_period) begin
                        if (own) begin
                            m_bad[l] = 0; e.lite[l] = 1'b1;
                        end else begin
                            m_bad[l]++;
                            if (m_bad[l] == BAD_N) begin m_mode[l] = 0; m_bad[l] = 0; drop = 1'b1; end
                        end
                    end
                endcase
            end
        end
        for (int l = 0; l < LANE_N; l++) begin
            m_seen[l]         = drop ? 1'b0 : (m_seen[l] || e.lite[l]);
            e.lock[l]         = (m_mode[l] == 2);
            e.ids[2*l +: 2]   = 2'(m_id[l]);
        end
        e.data   = d;
        e.data_v = dv;
        e.full   = all_lock && all_seen;
        e.err    = all_lock && dup;
    endtask

    task automatic drive_cycle(input bit rst, input logic [LANE_N-1:0] bl, input bit dv);
        wide_t d;
        exp_t  e;
        @(posedge clk);
        if (have_pend) exp_q.push_back(pend);
        #1;
        for (int l = 0; l < LANE_N; l++) begin
            bit due, cor;
            due = dv && am_en[l] && (((g_idx + GAP - off[l]) % GAP) == 0);
            if (dv && force_am[l]) begin due = 1'b1; force_am[l] = 1'b0; end
            cor = 1'b0;
            if (due) begin
                if (corrupt_n[l] > 0) begin cor = 1'b1; corrupt_n[l]--; end
                else if (corrupt_rand && ($urandom % 6) == 0) cor = 1'b1;
                d[l*BLOCK_W +: BLOCK_W] = make_am(gen_id[l], cor);
            end else begin
                d[l*BLOCK_W +: BLOCK_W] = rand_blk();
            end
        end
        reset      = rst;
        blk_lock_i = bl;
        data_v_i   = dv;
        data_i     = d;
        model_step(rst, bl, dv, d, e);
        pend      = e;
        have_pend = 1'b1;
        if (dv) g_idx++;
    endtask

    // Monitor: one expectation per clocked output cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_o",      data_o,              e.data);
                check("data_v_o",    wide_t'(data_v_o),    wide_t'(e.data_v));
                check("am_lite_v_o", wide_t'(am_lite_v_o), wide_t'(e.lite));
                check("am_lock_o",   wide_t'(am_lock_o),   wide_t'(e.lock));
                check("lane_id_o",   wide_t'(lane_id_o),   wide_t'(e.ids));
                check("lock_full",   wide_t'(full_o),      wide_t'(e.full));
                check("lane_id_err", wide_t'(id_err_o),    wide_t'(e.err));
            end
        end
    end

    initial begin
        int guard;
        for (int l = 0; l < LANE_N; l++) begin
            gen_id[l] = l; off[l] = 0; corrupt_n[l] = 0; am_en[l] = 1'b1; force_am[l] = 1'b0;
        end
        corrupt_rand = 1'b0;
        g_idx        = 0;

        // Aligned lock
        repeat (3) drive_cycle(1'b1, '0, 1'b0);
        repeat (52) drive_cycle(1'b0, 4'hF, 1'b1);
        check("lock_all_aligned", wide_t'(am_lock_o), wide_t'(4'hF));
        check("full_aligned",     wide_t'(full_o),    wide_t'(1'b1));

        // Mid-run reset, then lane 2 skewed by 5 blocks
        off[2] = 5;
        drive_cycle(1'b1, 4'hF, 1'b1);
        drive_cycle(1'b0, 4'hF, 1'b1);
        check("reset_lock",    wide_t'(am_lock_o), '0);
        check("reset_data_v",  wide_t'(data_v_o),  '0);
        check("reset_data",    data_o,             '0);
        check("reset_lane_id", wide_t'(lane_id_o), '0);
        check("reset_full",    wide_t'(full_o),    '0);
        repeat (60) drive_cycle(1'b0, 4'hF, 1'b1);
        check("skew_lane_id", wide_t'(lane_id_o), wide_t'(8'hE4));
        check("skew_full",    wide_t'(full_o),    wide_t'(1'b1));

        // Gearbox stalls: a fixed 3-cycle gap, then random gaps
        repeat (5) drive_cycle(1'b0, 4'hF, 1'b1);
        repeat (3) drive_cycle(1'b0, 4'hF, 1'b0);
        repeat (80) drive_cycle(1'b0, 4'hF, ($urandom % 4) != 0);
        check("stall_lock", wide_t'(am_lock_o), wide_t'(4'hF));

        // Four corrupted AMs on lane 0 lose lock; good AMs relock
        corrupt_n[0] = BAD_N;
        guard = 0;
        while (corrupt_n[0] != 0 && guard < 200) begin
            drive_cycle(1'b0, 4'hF, 1'b1);
            guard++;
        end
        check("corrupt_budget", wide_t'(corrupt_n[0]), '0);
        repeat (2) drive_cycle(1'b0, 4'hF, 1'b1);
        check("loss_lock0", wide_t'(am_lock_o[0]), '0);
        check("loss_full",  wide_t'(full_o),       '0);
        repeat (40) drive_cycle(1'b0, 4'hF, 1'b1);
        check("relock", wide_t'(am_lock_o), wide_t'(4'hF));

        // One-cycle block-lock loss on lane 0
        drive_cycle(1'b0, 4'b1110, 1'b1);
        repeat (2) drive_cycle(1'b0, 4'hF, 1'b1);
        check("blk_lock_lock0", wide_t'(am_lock_o[0]), '0);
        check("blk_lock_full",  wide_t'(full_o),       '0);
        repeat (40) drive_cycle(1'b0, 4'hF, 1'b1);

        // False candidate: a single lane-1 marker with no follow-up
        for (int l = 0; l < LANE_N; l++) am_en[l] = 1'b0;
        repeat (2) drive_cycle(1'b1, 4'hF, 1'b1);
        repeat (3) drive_cycle(1'b0, 4'hF, 1'b1);
        force_am[1] = 1'b1;
        repeat (40) drive_cycle(1'b0, 4'hF, 1'b1);
        check("false_cand_lock", wide_t'(am_lock_o), '0);

        // Duplicate id on lanes 1 and 3
        for (int l = 0; l < LANE_N; l++) begin am_en[l] = 1'b1; off[l] = 0; end
        gen_id[1] = 3;
        repeat (2) drive_cycle(1'b1, 4'hF, 1'b1);
        repeat (50) drive_cycle(1'b0, 4'hF, 1'b1);
        check("dup_lock", wide_t'(am_lock_o), wide_t'(4'hF));
        check("dup_err",  wide_t'(id_err_o),  wide_t'(1'b1));

        // Randomized soak: random ids/offsets, stalls, corruption, lock drops, resets
        for (int l = 0; l < LANE_N; l++) begin
            gen_id[l] = $urandom_range(0, 3);
            off[l]    = $urandom_range(0, GAP - 1);
        end
        corrupt_rand = 1'b1;
        repeat (400) begin
            logic [LANE_N-1:0] bl;
            for (int l = 0; l < LANE_N; l++) bl[l] = ($urandom % 80) != 0;
            drive_cycle(($urandom % 300) == 0, bl, ($urandom % 8) != 0);
        end

        @(posedge clk);
        if (have_pend) exp_q.push_back(pend);
        have_pend = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", wide_t'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/am_lock_rx.md
Name: am_lock_rx

Overview:
- Multi-lane alignment marker (AM) lock stage for the 40GBASE-R receive path.
- Sits after per-lane block sync and directly upstream of the per-lane deskew buffers.
- Runs one lock FSM per physical lane. It detects the lane's AM, confirms it at the AM period, and tracks lock.
- It forwards each lane's data with an aligned AM-valid pulse, and raises lock_full once every lane has locked and seen its AM.

Parameters:
- LANE_N, 4: number of physical lanes.
- BLOCK_W, 66: block width; bits [1:0] are the sync header.
- AM_GAP_N, 16384: blocks per AM period, including the AM itself. Set to 16 in simulation.
- AM_CNT_W, $clog2(AM_GAP_N): width of the period counter.
- AM_BAD_N, 4: consecutive bad AMs before lock is lost.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- blk_lock_i  in  LANE_N  per-lane block lock from block sync.
- data_v_i  in  1  a block is present on all lanes this cycle (gearbox stall when low).
- data_i  in  LANE_N*BLOCK_W  per-lane blocks; lane l occupies [l*BLOCK_W +: BLOCK_W].
- data_o  out  LANE_N*BLOCK_W  data_i delayed by one cycle.
- data_v_o  out  1  data_v_i delayed by one cycle.
- am_lite_v_o  out  LANE_N  block on data_o lane l is a confirmed AM of a locked lane.
- am_lock_o  out  LANE_N  per-lane AM lock.
- lane_id_o  out  LANE_N*2  logical lane id detected on each physical lane.
- am_lite_lock_full_v_o  out  1  all lanes locked and each has seen its AM.
- lane_id_err_o  out  1  all lanes locked but two lanes report the same id.

Behaviour:
- AM match on a block: sync header == 2'b10, and payload bytes {M0,M1,M2,M4,M5,M6} equal the package table entry for some id. M4..M6 are the bitwise inverses of M0..M2. BIP bytes are ignored. The match is combinational from data_i.
- Per-lane FSM states are SEARCH, CONFIRM and LOCKED. The period counter advances only when data_v_i is high.
- SEARCH:
  - On a valid block that matches any id: latch that id, clear the counter, go to CONFIRM.
  - Otherwise remain in SEARCH.
- CONFIRM:
  - When the counter reaches AM_GAP_N-1, check the block.
  - Same id matches: go to LOCKED, raise am_lock, emit am_lite_v for that block.
  - Otherwise: go to SEARCH. The current block is not re-examined as a new candidate.
- LOCKED, at counter == AM_GAP_N-1:
  - Match: clear bad_cnt and pulse am_lite_v.
  - Mismatch: increment bad_cnt. When bad_cnt reaches AM_BAD_N, go to SEARCH and drop am_lock on the next cycle.
- The counter wraps to 0 after AM_GAP_N-1.
- blk_lock_i[l] low in any state forces lane l to SEARCH next cycle and clears its bad_cnt, seen flag and am_lock. This takes priority over a simultaneous match.
- Latency:
  - data_o, data_v_o and am_lite_v_o are registered: one cycle after data_i.
  - am_lite_v_o is only ever high together with data_v_o.
- seen_q[l] is set when am_lite_v is emitted for lane l.
- seen_q is cleared for all lanes when any lane leaves LOCKED or loses block lock. The deskew skew counters then restart together.
- am_lite_lock_full_v_o = registered (&seen_q & &am_lock). It rises the cycle after the last lane's am_lite_v_o.
- am_lite_lock_full_v_o stays high while all lanes remain locked, and drops on the cycle following any lane leaving LOCKED.
- lane_id_err_o is registered. It is high when all lanes are locked and any two lane_id values are equal. It does not gate lock_full.
- Reset: all FSMs in SEARCH, counters 0, bad_cnt 0, seen_q 0. All outputs are 0, including data_o and lane_id_o.
- Reset asserted mid-period discards all lock state.

Decomposition:
- Package am_lock_pkg holds:
  - the AM marker table: the 40G lane 0..3 {M0,M1,M2} values 90/76/47, F0/C4/E6, C5/65/9B, A2/79/3D;
  - the sync header constant 2'b10;
  - the FSM state enum;
  - the lane id typedef.
- Sub-module am_lock_lane_rx: one lane's matcher, FSM, counter and bad_cnt. It is instantiated LANE_N times.
- The top level holds the data/valid pipeline register, seen_q, lock_full and the id-uniqueness check.

Test Plan:
- Lock: AM_GAP_N=16; lanes send ids 0..3 at the same offset, period 16, data_v_i always 1. am_lock_o=4'hF after the second AM. am_lite_v_o pulses every 16 cycles. lock_full rises one cycle after the 2nd AM pulse.
- Skewed lanes: lane 2 AM 5 blocks later than the others. am_lite_v_o[2] is 5 cycles after the others. lock_full rises the cycle after lane 2's pulse. lane_id_o = {3,2,1,0}.
- False candidate: a lane-1 pattern appears once, then no AM 16 blocks later. The FSM returns to SEARCH, am_lock_o[1]=0, and no am_lite_v pulse occurs.
- Loss: 3 corrupted AMs keep lock with no pulses. The 4th corrupted AM makes am_lock drop and lock_full drop on the next cycle. A good AM follows: relock only after two periods.
- Stalls/blk_lock: data_v_i low for 3 cycles mid-period leaves the pulse position unchanged in valid blocks. blk_lock_i[0] low for 1 cycle gives am_lock_o[0]=0 and lock_full=0. Mid-run reset: all outputs 0 the next cycle.
- Duplicate id: two lanes send lane-3 markers. Both lock and lane_id_err_o=1.
